mips_multi_core: RTL
====================

MIPS_MULTI_CORE -- requirements
Module: mips_multi_core

Interface
REQ-001 Parameter MEM_DEPTH, default 64, unified instruction/data memory depth in 32-bit words; power of two, 16..1024.
REQ-002 Parameter RESET_PC, default 0, PC value after reset and on restart; word-aligned.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run_i  in  1  start/restart execution request.
REQ-006 prog_we_i  in  1  program-load write strobe.
REQ-007 prog_addr_i  in  $clog2(MEM_DEPTH)  program-load word address.
REQ-008 prog_data_i  in  32  program-load write data.
REQ-009 halted_o  out  1  core is in HALT.
REQ-010 illegal_o  out  1  last halt was caused by an unsupported opcode or funct.
REQ-011 pc_o  out  32  current PC.
REQ-012 instr_o  out  32  instruction register contents.
REQ-013 alu_out_o  out  32  registered ALU result.
REQ-014 state_o  out  4  FSM state encoding, per REQ-018.

Function
REQ-015 Memory SHALL be word-addressed by byte address bits [$clog2(MEM_DEPTH)+1:2], with upper bits ignored (wrap-around); combinational read, write on clock edge.
REQ-016 Register file SHALL hold 32x32 registers, with $0 reading zero and writes to $0 discarded; two combinational read ports and one synchronous write port.
REQ-017 Datapath SHALL register IR (written in FETCH only), MDR, A, B and ALUOut every cycle, as a classic multicycle MIPS.
REQ-018 States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXECUTE=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, HALT=13.
REQ-019 IDLE SHALL go to FETCH when run_i=1, otherwise remain in IDLE.
REQ-020 FETCH SHALL perform IR<=mem[PC] and PC<=PC+4, then go to DECODE.
REQ-021 DECODE SHALL compute ALUOut<=PC+(signext(imm)<<2) and dispatch on opcode.
REQ-022 Dispatch: lw 0x23/sw 0x2B->MEMADR; R-type 0x00->EXECUTE; beq 0x04->BRANCH; addi 0x08->ADDIEX; j 0x02->JUMP; 0x3F->HALT with illegal_o=0; any other opcode->HALT with illegal_o=1.
REQ-023 R-type funct SHALL be add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); any other funct SHALL go from EXECUTE to HALT with illegal_o=1 and no register write.
REQ-024 Instruction latency SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; after each, the next state is FETCH.
REQ-025 beq SHALL load PC<=ALUOut when A==B, otherwise leave PC unchanged.
REQ-026 j SHALL load PC<={PC[31:28], instr[25:0], 2'b00}.
REQ-027 Arithmetic SHALL be 32-bit, wrapping, with no overflow trap.
REQ-028 prog_we_i SHALL write memory only in IDLE or HALT, and SHALL be ignored in all other states.
REQ-029 run_i in HALT SHALL set PC<=RESET_PC, clear illegal_o and go to FETCH, with registers and memory preserved.
REQ-030 run_i SHALL be ignored in all states other than IDLE and HALT.
REQ-031 halted_o SHALL equal (state==HALT).

Reset
REQ-032 reset SHALL force state IDLE, PC=RESET_PC, IR/MDR/A/B/ALUOut=0, all registers=0, illegal_o=0, halted_o=0, and SHALL take priority over run_i and prog_we_i.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 reset asserted mid-instruction SHALL abort the instruction with no partial register or memory write on that edge.

Configuration
REQ-035 With MIPS_BNE_EN defined, opcode 0x05 (bne) SHALL dispatch to BRANCH and load PC<=ALUOut when A!=B, in 3 cycles.
REQ-036 Without MIPS_BNE_EN, opcode 0x05 SHALL be treated as illegal per REQ-022.

Verification
REQ-037 Program load: load addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; halt; pulse run_i -> HALT with $3=12, illegal_o=0, 14 cycles from FETCH entry to HALT.
REQ-038 Memory: sw $3,0x40($0) then lw $4,0x40($0) -> mem word 16 holds 12 and $4=12; with MEM_DEPTH=16, address 0x40 aliases to word 0.
REQ-039 Branch: beq $1,$1,-1 loop with reset asserted after 20 cycles -> IDLE, PC=RESET_PC, registers cleared, memory unchanged.
REQ-040 Illegal: opcode 0x05 -> illegal_o=1 and PC=instruction address+4 without MIPS_BNE_EN; bne taken with it defined.
REQ-041 Protection: prog_we_i pulsed during EXECUTE -> memory unchanged; run_i pulsed mid-instruction -> no effect on state sequence.
REQ-042 Edge cases: write to $0 then read $0 -> 0; sub 0-1 -> 0xFFFFFFFF; slt -1,1 -> 1.

Source files
------------

// File: rtl/mips_multi_core_if.sv
// mips_multi_core_if: run control, program-load port and status outputs
// of the multicycle MIPS core. The master side is the host or testbench.
// The slave side is the core.
interface mips_multi_core_if #(
  parameter int MEM_DEPTH = 64
) ();
  localparam int AW = $clog2(MEM_DEPTH);

  logic          run_i;
  logic          prog_we_i;
  logic [AW-1:0] prog_addr_i;
  logic [31:0]   prog_data_i;
  logic          halted_o;
  logic          illegal_o;
  logic [31:0]   pc_o;
  logic [31:0]   instr_o;
  logic [31:0]   alu_out_o;
  logic [3:0]    state_o;

  modport master (
    output run_i, prog_we_i, prog_addr_i, prog_data_i,
    input  halted_o, illegal_o, pc_o, instr_o, alu_out_o, state_o
  );

  modport slave (
    input  run_i, prog_we_i, prog_addr_i, prog_data_i,
    output halted_o, illegal_o, pc_o, instr_o, alu_out_o, state_o
  );
endinterface

// File: rtl/mips_multi_core.sv
// mips_multi_core: classic multicycle MIPS subset (lw, sw, R-type add/sub/
// and/or/slt, beq, addi, j, halt). It uses a unified word-addressed memory
// and a 32x32 register file.
// Optional feature: define MIPS_BNE_EN to add bne (opcode 0x05).
module mips_multi_core #(
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  mips_multi_core_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MIPS_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_MEMADR  = 4'd3,
    ST_MEMRD   = 4'd4,
    ST_MEMWB   = 4'd5,
    ST_MEMWR   = 4'd6,
    ST_EXECUTE = 4'd7,
    ST_ALUWB   = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_ADDIEX  = 4'd10,
    ST_ADDIWB  = 4'd11,
    ST_JUMP    = 4'd12,
    ST_HALT    = 4'd13
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;
  logic        illegal;

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] rf  [32];

  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [5:0]    funct;
  logic [31:0]   imm_ext;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_rdata;
  logic [31:0]   alu_result;
  logic          funct_ok;
  logic          branch_taken;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign imm_ext = {{16{ir[15]}}, ir[15:0]};

  // The instruction fetch uses the PC. Every data access uses the address held in ALUOut.
  assign mem_idx   = (state == ST_FETCH) ? pc[AW+1:2] : alu_out[AW+1:2];
  assign mem_rdata = mem[mem_idx];

  // The shared ALU. Each state selects its operands and operation. The default is PC+4.
  always_comb begin
    alu_result = pc + 32'd4;
    funct_ok   = 1'b1;
    case (state)
      ST_DECODE:            alu_result = pc + (imm_ext << 2);
      ST_MEMADR, ST_ADDIEX: alu_result = a_reg + imm_ext;
      ST_BRANCH:            alu_result = a_reg - b_reg;
      ST_EXECUTE: begin
        case (funct)
          6'h20:   alu_result = a_reg + b_reg;
          6'h22:   alu_result = a_reg - b_reg;
          6'h24:   alu_result = a_reg & b_reg;
          6'h25:   alu_result = a_reg | b_reg;
          6'h2A:   alu_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
          default: begin
            alu_result = 32'd0;
            funct_ok   = 1'b0;
          end
        endcase
      end
      default: ;
    endcase
  end

  // The branch condition. It is equality for beq, and inequality for bne when bne is enabled.
  always_comb begin
`ifdef MIPS_BNE_EN
    branch_taken = (opcode == OP_BNE) ? (a_reg != b_reg) : (a_reg == b_reg);
`else
    branch_taken = (a_reg == b_reg);
`endif
  end

  // Register write-back select. Only the three write-back states write a register.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_out;
    case (state)
      ST_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr;
      end
      ST_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
      end
      ST_ADDIWB: rf_we = 1'b1;
      default: ;
    endcase
  end

  // The register file. Reset clears it. Writes to $0 are dropped, so $0 always reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  // Memory write. Reset leaves the contents alone but blocks the write on that edge. Program load works only while stopped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_MEMWR) begin
        mem[alu_out[AW+1:2]] <= b_reg;
      end else if (bus.prog_we_i && (state == ST_IDLE || state == ST_HALT)) begin
        mem[bus.prog_addr_i] <= bus.prog_data_i;
      end
    end
  end

  // Datapath registers. IR loads only in FETCH. MDR, A, B and ALUOut reload every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      alu_out <= 32'd0;
    end else begin
      if (state == ST_FETCH) ir <= mem_rdata;
      mdr     <= mem_rdata;
      a_reg   <= rf[rs];
      b_reg   <= rf[rt];
      alu_out <= alu_result;
    end
  end

  // Control FSM. It also owns the PC and the sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.run_i) begin
            pc    <= RESET_PC;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          pc    <= alu_result;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= ST_MEMADR;
            OP_RTYPE:     state <= ST_EXECUTE;
            OP_BEQ:       state <= ST_BRANCH;
`ifdef MIPS_BNE_EN
            OP_BNE:       state <= ST_BRANCH;
`endif
            OP_ADDI:      state <= ST_ADDIEX;
            OP_J:         state <= ST_JUMP;
            OP_HALT: begin
              illegal <= 1'b0;
              state   <= ST_HALT;
            end
            default: begin
              illegal <= 1'b1;
              state   <= ST_HALT;
            end
          endcase
        end
        ST_MEMADR:  state <= (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
        ST_MEMRD:   state <= ST_MEMWB;
        ST_MEMWB:   state <= ST_FETCH;
        ST_MEMWR:   state <= ST_FETCH;
        ST_EXECUTE: begin
          if (funct_ok) begin
            state <= ST_ALUWB;
          end else begin
            illegal <= 1'b1;
            state   <= ST_HALT;
          end
        end
        ST_ALUWB:   state <= ST_FETCH;
        ST_BRANCH: begin
          if (branch_taken) pc <= alu_out;
          state <= ST_FETCH;
        end
        ST_ADDIEX:  state <= ST_ADDIWB;
        ST_ADDIWB:  state <= ST_FETCH;
        ST_JUMP: begin
          pc    <= {pc[31:28], ir[25:0], 2'b00};
          state <= ST_FETCH;
        end
        ST_HALT: begin
          if (bus.run_i) begin
            pc      <= RESET_PC;
            illegal <= 1'b0;
            state   <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.halted_o  = (state == ST_HALT);
  assign bus.illegal_o = illegal;
  assign bus.pc_o      = pc;
  assign bus.instr_o   = ir;
  assign bus.alu_out_o = alu_out;
  assign bus.state_o   = state;
endmodule
